uart_cmd_ctrl: RTL
==================

# uart_cmd_ctrl

Command-level controller between the UART receiver byte stream and the SoC's 8-bit register bus. Collects framed command packets from received bytes, checks them, issues one register write or read, and returns a one-byte response to the UART transmitter. Owns packet sequencing, inter-byte timeout and error accounting, so the receiver stays a pure byte deserializer.

## Interface
- CLK_FREQ_HZ, 30000000, system clock frequency
- BAUD_RATE, 115200, UART bit rate
- TIMEOUT_BYTES, 4, inter-byte timeout in byte times; one byte time = 10*CLK_FREQ_HZ/BAUD_RATE cycles
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  byte valid; level may be held for many cycles, a byte is taken only on its 0->1 edge
- o_rx_ready  out  1  high while the FSM is in SYNC..CHK
- o_reg_we  out  1  register write strobe, one cycle
- o_reg_re  out  1  register read strobe, one cycle
- o_reg_addr  out  8  register address
- o_reg_wdata  out  8  write data
- i_reg_rdata  in  8  read data
- i_reg_rvalid  in  1  read data valid
- o_tx_data  out  8  response byte
- o_tx_valid  out  1  response valid
- i_tx_ready  in  1  transmitter accepts
- o_err_cnt  out  8  saturating error count

## Operation
- Byte strobe = i_rx_valid & ~rx_valid_q. rx_valid_q resets to 0.
- Packet: SYNC 0xA5, CMD, ADDR, DATA, CHK. CHK = CMD ^ ADDR ^ DATA. DATA is always present. CMD 0x01 = write, 0x02 = read.
- FSM states: SYNC, CMD, ADDR, DATA, CHK, EXEC, RD_WAIT, RESP.
- SYNC: a strobe with 0xA5 goes to CMD. Any other byte is discarded without error.
- CMD/ADDR/DATA/CHK: each strobe latches the byte and advances.
- After CHK is accepted:
  - checksum bad or CMD unknown -> RESP with 0xEE (NAK); o_err_cnt increments.
  - otherwise -> EXEC.
- EXEC, write: o_reg_we=1 for one cycle with addr/wdata, then RESP with 0x5A (ACK).
- EXEC, read: o_reg_re=1 for one cycle, then RD_WAIT. On i_reg_rvalid, capture i_reg_rdata and go to RESP with that byte.
- RESP: o_tx_valid held high and o_tx_data stable until the cycle i_tx_ready=1. Then go to SYNC.
- Strobes in EXEC/RD_WAIT/RESP: byte discarded, o_err_cnt increments.
- Timeout counter:
  - runs only in CMD..CHK and clears on every strobe.
  - on reaching TIMEOUT_BYTES byte times, go to SYNC silently (no response) and increment o_err_cnt.
- o_err_cnt saturates at 255. It never wraps.

## Timing
- Reset values: o_rx_ready=1, o_reg_we=0, o_reg_re=0, o_reg_addr=0, o_reg_wdata=0, o_tx_data=0, o_tx_valid=0, o_err_cnt=0. FSM starts in SYNC with the timeout counter at 0.
- Write strobe: CHK byte strobe sampled at edge N gives o_reg_we high in cycle N+1 only. o_tx_valid rises in cycle N+2.
- Read strobe: o_reg_re high in cycle N+1. If i_reg_rvalid is sampled at edge M, o_tx_valid rises in cycle M+1.
- i_reg_rvalid outside RD_WAIT is ignored.
- NAK: o_tx_valid rises in cycle N+1 after the bad CHK strobe.
- A strobe and timeout expiry in the same cycle: the byte wins and the counter clears.
- A discard-error and a NAK/timeout error in the same cycle: increment once only.
- All outputs are registered.
- Reset mid-packet or mid-response: everything returns to reset values, and a pending response is dropped.
- A valid level held across reset does not produce a strobe until it drops and rises again.

## Configuration
- UART_CMD_CHECKSUM_EN
  - Defined: CHK byte and checking exactly as above.
  - Undefined: packet ends at DATA, and the CHK state is removed.
  - EXEC (or NAK for unknown CMD) follows the DATA strobe with the same N+1 timing.

## Test plan
- Write: A5 01 10 3C 2D -> o_reg_we pulse, addr 0x10, wdata 0x3C; then o_tx_data 0x5A, o_err_cnt 0.
- Read: A5 02 22 00 20, slave returns 0x99 three cycles after o_reg_re -> o_tx_data 0x99 one cycle after rvalid. Hold i_tx_ready low 5 cycles: data stable throughout.
- Bad checksum: A5 01 10 3C 00 -> no o_reg_we, response 0xEE, o_err_cnt=1. Unknown CMD 0x07 with correct CHK -> 0xEE, o_err_cnt=2.
- Timeout: A5 01, then idle > 4 byte times -> back to SYNC, no response, o_err_cnt=1. A following valid packet completes normally.
- Held valid: i_rx_valid high 40 cycles per byte -> each byte taken exactly once. Noise bytes 0x00 0xFF before sync are ignored, err unchanged.
- Saturation and reset: 300 bad packets -> o_err_cnt=255. i_rst asserted during RESP -> o_tx_valid=0 next cycle, counter=0.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Command packet controller between a UART byte stream and an 8-bit register bus.
// Optional checksum byte enabled by defining UART_CMD_CHECKSUM_EN.
`timescale 1ns / 1ps

module uart_cmd_ctrl #(
   parameter int unsigned CLK_FREQ_HZ   = 30000000,
   parameter int unsigned BAUD_RATE     = 115200,
   parameter int unsigned TIMEOUT_BYTES = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic       o_rx_ready,
   output logic       o_reg_we,
   output logic       o_reg_re,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_reg_wdata,
   input  logic [7:0] i_reg_rdata,
   input  logic       i_reg_rvalid,
   output logic [7:0] o_tx_data,
   output logic       o_tx_valid,
   input  logic       i_tx_ready,
   output logic [7:0] o_err_cnt
);

   localparam int unsigned ByteCycles    = (10 * CLK_FREQ_HZ) / BAUD_RATE;
   localparam int unsigned TimeoutCycles = TIMEOUT_BYTES * ByteCycles;
   localparam int unsigned TmoW          = $clog2(TimeoutCycles + 1);
   localparam logic [TmoW-1:0] TmoLast   = TmoW'(TimeoutCycles - 1);

   localparam logic [7:0] SyncByte = 8'hA5;
   localparam logic [7:0] CmdWrite = 8'h01;
   localparam logic [7:0] CmdRead  = 8'h02;
   localparam logic [7:0] AckByte  = 8'h5A;
   localparam logic [7:0] NakByte  = 8'hEE;

   typedef enum logic [2:0] {
      StSync,
      StCmd,
      StAddr,
      StData,
`ifdef UART_CMD_CHECKSUM_EN
      StChk,
`endif
      StExec,
      StRdWait,
      StResp
   } state_e;

   state_e          state_q, state_d;
   logic            rx_valid_q, rx_valid_d;
   logic            rx_armed_q, rx_armed_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            we_q, we_d;
   logic            re_q, re_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic [7:0]      err_q, err_d;
   logic            rx_ready_q, rx_ready_d;

   logic strobe;
   logic busy;
   logic in_rx;
   logic cmd_known;
   logic end_pkt;
   logic pkt_good;
   logic err_inc;

   // The armed flag blocks a valid level that was already high when reset released.
   assign strobe    = i_rx_valid & ~rx_valid_q & rx_armed_q;
   assign busy      = (state_q == StExec) || (state_q == StRdWait) || (state_q == StResp);
   assign in_rx     = (state_q != StSync) && !busy;
   assign cmd_known = (cmd_q == CmdWrite) || (cmd_q == CmdRead);

   always_comb begin
      state_d    = state_q;
      rx_valid_d = i_rx_valid;
      rx_armed_d = rx_armed_q | ~i_rx_valid;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      tmo_d      = '0;
      we_d       = 1'b0;
      re_d       = 1'b0;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      err_d      = err_q;
      rx_ready_d = 1'b1;
      end_pkt    = 1'b0;
      pkt_good   = 1'b0;
      err_inc    = 1'b0;

      case (state_q)
         StSync: begin
            if (strobe && (i_rx_data == SyncByte)) begin
               state_d = StCmd;
            end
         end
         StCmd: begin
            if (strobe) begin
               cmd_d   = i_rx_data;
               state_d = StAddr;
            end
         end
         StAddr: begin
            if (strobe) begin
               addr_d  = i_rx_data;
               state_d = StData;
            end
         end
         StData: begin
            if (strobe) begin
               wdata_d = i_rx_data;
`ifdef UART_CMD_CHECKSUM_EN
               state_d = StChk;
`else
               end_pkt  = 1'b1;
               pkt_good = cmd_known;
`endif
            end
         end
`ifdef UART_CMD_CHECKSUM_EN
         StChk: begin
            if (strobe) begin
               end_pkt  = 1'b1;
               pkt_good = cmd_known && ((cmd_q ^ addr_q ^ wdata_q) == i_rx_data);
            end
         end
`endif
         StExec: begin
            if (cmd_q == CmdWrite) begin
               tx_data_d  = AckByte;
               tx_valid_d = 1'b1;
               state_d    = StResp;
            end else begin
               state_d = StRdWait;
            end
         end
         StRdWait: begin
            if (i_reg_rvalid) begin
               tx_data_d  = i_reg_rdata;
               tx_valid_d = 1'b1;
               state_d    = StResp;
            end
         end
         StResp: begin
            if (i_tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = StSync;
            end
         end
         default: state_d = StSync;
      endcase

      // Strobes are registered one edge ahead so the bus pulse lands in the EXEC cycle.
      if (end_pkt) begin
         if (pkt_good) begin
            state_d = StExec;
            we_d    = (cmd_q == CmdWrite);
            re_d    = (cmd_q == CmdRead);
         end else begin
            state_d    = StResp;
            tx_data_d  = NakByte;
            tx_valid_d = 1'b1;
            err_inc    = 1'b1;
         end
      end

      // A strobe in the expiry cycle wins: the counter simply clears.
      if (in_rx && !strobe) begin
         if (tmo_q == TmoLast) begin
            state_d = StSync;
            err_inc = 1'b1;
         end else begin
            tmo_d = tmo_q + TmoW'(1);
         end
      end

      if (strobe && busy) begin
         err_inc = 1'b1;
      end

      if (err_inc && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end

      rx_ready_d = (state_d != StExec) && (state_d != StRdWait) && (state_d != StResp);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StSync;
         rx_valid_q <= 1'b0;
         rx_armed_q <= 1'b0;
         cmd_q      <= 8'h00;
         addr_q     <= 8'h00;
         wdata_q    <= 8'h00;
         tmo_q      <= '0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         err_q      <= 8'h00;
         rx_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         rx_valid_q <= rx_valid_d;
         rx_armed_q <= rx_armed_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         tmo_q      <= tmo_d;
         we_q       <= we_d;
         re_q       <= re_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         err_q      <= err_d;
         rx_ready_q <= rx_ready_d;
      end
   end

   assign o_rx_ready  = rx_ready_q;
   assign o_reg_we    = we_q;
   assign o_reg_re    = re_q;
   assign o_reg_addr  = addr_q;
   assign o_reg_wdata = wdata_q;
   assign o_tx_data   = tx_data_q;
   assign o_tx_valid  = tx_valid_q;
   assign o_err_cnt   = err_q;

endmodule
